exc_ctrl: RTL and testbench
===========================

# exc_ctrl

Exception and pipeline-control stage sitting between the MEM stage and the CP0 register file and PC. It takes raw per-cause exception flags from MEM and forwards in-flight CP0 writes from WB. It also resolves interrupt eligibility and priority, then drives the encoded exception type into CP0. In the same cycle it raises pipeline flush, supplies the redirect PC and arbitrates stall requests. A small state machine enforces a one-cycle post-flush blackout and holds interrupts that arrive while MEM carries a bubble.

## Interface
- EXC_VECTOR, 32'h0000_0020, redirect target for every exception except eret
- CNT_W, 16, width of saturating taken-exception counter
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_valid_i  in  1  MEM holds a real instruction (not a bubble)
- mem_pc_i  in  32  PC of MEM instruction
- mem_in_delayslot_i  in  1  MEM instruction is in a branch delay slot
- mem_addr_i  in  32  data access address of MEM instruction
- exc_fetch_adel_i, exc_ri_i, exc_syscall_i, exc_break_i, exc_trap_i, exc_ov_i, exc_adel_i, exc_ades_i, exc_eret_i  in  1 each  raw cause flags from MEM
- cp0_status_i, cp0_cause_i, cp0_epc_i  in  32  current CP0 register values
- wb_cp0_we_i  in  1  WB-stage CP0 write enable
- wb_cp0_waddr_i  in  5  WB CP0 write address (12 status, 13 cause, 14 epc)
- wb_cp0_data_i  in  32  WB CP0 write data
- stallreq_id_i, stallreq_ex_i, stallreq_mem_i  in  1  stage stall requests
- excepttype_o  out  32  encoded exception to CP0 (0 = none)
- exc_pc_o  out  32  PC passed to CP0 for EPC
- exc_in_delayslot_o  out  1  delay-slot flag passed to CP0
- badvaddr_o  out  32  faulting address passed to CP0
- flush_o  out  1  flush all pipeline registers
- new_pc_o  out  32  redirect PC, valid when flush_o
- stall_o  out  6  {wb,mem,ex,id,if,pc} hold vector
- exc_cnt_o  out  CNT_W  exceptions taken, saturating

## Operation
- Forwarding: effective status/cause/epc use wb_cp0_data_i when wb_cp0_we_i is high and the address matches; otherwise the CP0 input is used. For cause, only bits [9:8], 22 and 23 are overridden.
- Interrupt eligible: (cause[15:8] & status[15:8]) != 0, status[0]==1 and status[1]==0, all from effective values.
- Priority, highest first: interrupt 0x1, fetch AdEL 0x4, RI 0xa, syscall 0x8, break 0x9, trap 0xd, overflow 0xc, data AdEL 0x4, AdES 0x5, eret 0xe.
- badvaddr_o: mem_pc_i for fetch AdEL; otherwise mem_addr_i.
- Non-interrupt causes count only when mem_valid_i is high.
- FSM states:
  - IDLE: evaluate every cycle; any taken type -> drive outputs and go to BLACKOUT.
  - BLACKOUT: excepttype_o=0 and flush_o=0 for exactly one cycle; return to IDLE.
- int_pend register: set when an interrupt is eligible but mem_valid_i=0 or the state is BLACKOUT. It is cleared when the interrupt is taken or eligibility drops. The interrupt is taken in the first IDLE cycle with mem_valid_i=1.
- new_pc_o: effective EPC for eret; EXC_VECTOR otherwise; 0 when no flush.
- stall_o:
  - mem request -> 6'b011111
  - else ex -> 6'b001111
  - else id -> 6'b000111
  - else 0
  - forced 0 when flush_o=1
- exc_cnt_o increments on each cycle with flush_o=1, saturating at all ones; eret counts.

## Timing
- excepttype_o, flush_o, new_pc_o, stall_o and the pass-through outputs are combinational from inputs and state. CP0 captures them at the same edge the pipeline flushes.
- State, int_pend and exc_cnt_o are registered.
- Reset values: state IDLE, int_pend 0, exc_cnt_o 0. Combinational outputs are all 0 while rst is high.
- Simultaneous WB CP0 write and MEM exception: forwarded value wins, e.g. a write clearing IE suppresses the interrupt in that same cycle.
- Exception during BLACKOUT is ignored. MEM is a bubble in that cycle by construction.
- Reset asserted mid-BLACKOUT returns to IDLE next edge with no flush.

## Structure
- Shared package/defines: exception codes (0x1, 0x4, 0x5, 0x8, 0x9, 0xa, 0xc, 0xd, 0xe), CP0 addresses 12/13/14, EXC_VECTOR, stall-vector constants.
- One sub-module, cp0_fwd: combinational status/cause/epc forwarding mux.

## Test plan
- exc_syscall_i=1, mem_pc_i=0x100, status EXL=0 -> excepttype_o=0x8, flush_o=1, new_pc_o=0x20; next cycle flush_o=0; exc_cnt_o=1.
- exc_eret_i=1, cp0_epc_i=0x200, WB writes epc=0x300 same cycle -> excepttype_o=0xe, new_pc_o=0x300.
- cause IP2 and status IM2 set, IE=1, mem_valid_i=0 for 3 cycles, then 1 -> no flush for 3 cycles, then excepttype_o=0x1.
- exc_ri_i and exc_ov_i together with mem_valid_i=1 -> excepttype_o=0xa. Two back-to-back syscalls -> the second is dropped in BLACKOUT.
- stallreq_ex_i=1 -> stall_o=6'b001111. Add exc_adel_i, mem_addr_i=0x1001 -> stall_o=0, excepttype_o=0x4, badvaddr_o=0x1001.
- exc_cnt_o preloaded near max via 2^CNT_W flushes -> holds at all ones. rst mid-BLACKOUT -> exc_cnt_o=0, flush_o=0.

Source files
------------

// File: rtl/exc_ctrl_pkg.sv
// exc_ctrl_pkg: shared exception codes, CP0 addresses, stall vectors and FSM states
package exc_ctrl_pkg;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;
    localparam logic [31:0] EXC_INT  = 32'h1;
    localparam logic [31:0] EXC_ADEL = 32'h4;
    localparam logic [31:0] EXC_ADES = 32'h5;
    localparam logic [31:0] EXC_SYS  = 32'h8;
    localparam logic [31:0] EXC_BP   = 32'h9;
    localparam logic [31:0] EXC_RI   = 32'ha;
    localparam logic [31:0] EXC_OV   = 32'hc;
    localparam logic [31:0] EXC_TR   = 32'hd;
    localparam logic [31:0] EXC_ERET = 32'he;
    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_NONE = 6'b000000;
    typedef enum logic {IDLE, BLACKOUT} state_t;
endpackage

// File: rtl/exc_ctrl_cp0_fwd.sv
// exc_ctrl_cp0_fwd: forwards an in-flight WB CP0 write onto status/cause/epc
module exc_ctrl_cp0_fwd
    import exc_ctrl_pkg::*;
(
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [31:0] status,
    input  logic [31:0] cause,
    input  logic [31:0] epc,
    output logic [31:0] status_eff,
    output logic [31:0] cause_eff,
    output logic [31:0] epc_eff
);
    always_comb begin
        status_eff = (we && waddr == CP0_STATUS) ? wdata : status;
        epc_eff = (we && waddr == CP0_EPC) ? wdata : epc;
        cause_eff = cause;
        // only the software-writable cause fields are forwarded
        if (we && waddr == CP0_CAUSE) begin
            cause_eff[23:22] = wdata[23:22];
            cause_eff[9:8] = wdata[9:8];
        end
    end
endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception priority, flush/redirect, stall arbitration and post-flush blackout
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid_i,
    input  logic [31:0]      mem_pc_i,
    input  logic             mem_in_delayslot_i,
    input  logic [31:0]      mem_addr_i,
    input  logic             exc_fetch_adel_i,
    input  logic             exc_ri_i,
    input  logic             exc_syscall_i,
    input  logic             exc_break_i,
    input  logic             exc_trap_i,
    input  logic             exc_ov_i,
    input  logic             exc_adel_i,
    input  logic             exc_ades_i,
    input  logic             exc_eret_i,
    input  logic [31:0]      cp0_status_i,
    input  logic [31:0]      cp0_cause_i,
    input  logic [31:0]      cp0_epc_i,
    input  logic             wb_cp0_we_i,
    input  logic [4:0]       wb_cp0_waddr_i,
    input  logic [31:0]      wb_cp0_data_i,
    input  logic             stallreq_id_i,
    input  logic             stallreq_ex_i,
    input  logic             stallreq_mem_i,
    output logic [31:0]      excepttype_o,
    output logic [31:0]      exc_pc_o,
    output logic             exc_in_delayslot_o,
    output logic [31:0]      badvaddr_o,
    output logic             flush_o,
    output logic [31:0]      new_pc_o,
    output logic [5:0]       stall_o,
    output logic [CNT_W-1:0] exc_cnt_o
);
    state_t state, state_nx;
    logic int_pend;
    logic int_eligible;
    logic [31:0] status_eff, cause_eff, epc_eff, sync_type;
    logic unused_bits;

    exc_ctrl_cp0_fwd u_cp0_fwd (
        .we(wb_cp0_we_i),
        .waddr(wb_cp0_waddr_i),
        .wdata(wb_cp0_data_i),
        .status(cp0_status_i),
        .cause(cp0_cause_i),
        .epc(cp0_epc_i),
        .status_eff(status_eff),
        .cause_eff(cause_eff),
        .epc_eff(epc_eff)
    );

    assign int_eligible = |(cause_eff[15:8] & status_eff[15:8]) && status_eff[0] && !status_eff[1];
    assign unused_bits = ^{status_eff[31:16], status_eff[7:2], cause_eff[31:16], cause_eff[7:0]};

    always_comb begin
        sync_type = exc_fetch_adel_i ? EXC_ADEL :
                    exc_ri_i         ? EXC_RI   :
                    exc_syscall_i    ? EXC_SYS  :
                    exc_break_i      ? EXC_BP   :
                    exc_trap_i       ? EXC_TR   :
                    exc_ov_i         ? EXC_OV   :
                    exc_adel_i       ? EXC_ADEL :
                    exc_ades_i       ? EXC_ADES :
                    exc_eret_i       ? EXC_ERET : '0;
        // interrupts, like synchronous causes, wait for a real instruction in IDLE
        excepttype_o = (rst || state != IDLE || !mem_valid_i) ? '0 : int_eligible ? EXC_INT : sync_type;
        flush_o = excepttype_o != '0;
        new_pc_o = !flush_o ? '0 : excepttype_o == EXC_ERET ? epc_eff : EXC_VECTOR;
        stall_o = (rst || flush_o) ? STALL_NONE :
                  stallreq_mem_i   ? STALL_MEM  :
                  stallreq_ex_i    ? STALL_EX   :
                  stallreq_id_i    ? STALL_ID   : STALL_NONE;
        exc_pc_o = rst ? '0 : mem_pc_i;
        exc_in_delayslot_o = !rst && mem_in_delayslot_i;
        badvaddr_o = rst ? '0 : exc_fetch_adel_i ? mem_pc_i : mem_addr_i;
        state_nx = (state == IDLE && flush_o) ? BLACKOUT : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            int_pend <= 1'b0;
            exc_cnt_o <= '0;
        end else begin
            state <= state_nx;
            int_pend <= int_eligible && excepttype_o != EXC_INT &&
                        (int_pend || !mem_valid_i || state == BLACKOUT);
            if (flush_o && !(&exc_cnt_o))
                exc_cnt_o <= exc_cnt_o + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed self-checking bench for exc_ctrl
module tb_exc_ctrl;
    localparam int CW = 4;
    logic clk = 1'b0;
    logic rst;
    logic mem_valid_i, mem_in_delayslot_i;
    logic [31:0] mem_pc_i, mem_addr_i;
    logic exc_fetch_adel_i, exc_ri_i, exc_syscall_i, exc_break_i, exc_trap_i;
    logic exc_ov_i, exc_adel_i, exc_ades_i, exc_eret_i;
    logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
    logic wb_cp0_we_i;
    logic [4:0] wb_cp0_waddr_i;
    logic [31:0] wb_cp0_data_i;
    logic stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
    logic [31:0] excepttype_o, exc_pc_o, badvaddr_o, new_pc_o;
    logic exc_in_delayslot_o, flush_o;
    logic [5:0] stall_o;
    logic [CW-1:0] exc_cnt_o;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    exc_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i),
        .mem_in_delayslot_i(mem_in_delayslot_i), .mem_addr_i(mem_addr_i),
        .exc_fetch_adel_i(exc_fetch_adel_i), .exc_ri_i(exc_ri_i),
        .exc_syscall_i(exc_syscall_i), .exc_break_i(exc_break_i),
        .exc_trap_i(exc_trap_i), .exc_ov_i(exc_ov_i), .exc_adel_i(exc_adel_i),
        .exc_ades_i(exc_ades_i), .exc_eret_i(exc_eret_i),
        .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
        .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i),
        .wb_cp0_data_i(wb_cp0_data_i),
        .stallreq_id_i(stallreq_id_i), .stallreq_ex_i(stallreq_ex_i),
        .stallreq_mem_i(stallreq_mem_i),
        .excepttype_o(excepttype_o), .exc_pc_o(exc_pc_o),
        .exc_in_delayslot_o(exc_in_delayslot_o), .badvaddr_o(badvaddr_o),
        .flush_o(flush_o), .new_pc_o(new_pc_o), .stall_o(stall_o),
        .exc_cnt_o(exc_cnt_o)
    );

    task automatic clr();
        mem_valid_i = 0; mem_in_delayslot_i = 0; mem_pc_i = 0; mem_addr_i = 0;
        exc_fetch_adel_i = 0; exc_ri_i = 0; exc_syscall_i = 0; exc_break_i = 0;
        exc_trap_i = 0; exc_ov_i = 0; exc_adel_i = 0; exc_ades_i = 0; exc_eret_i = 0;
        cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0;
        wb_cp0_we_i = 0; wb_cp0_waddr_i = 0; wb_cp0_data_i = 0;
        stallreq_id_i = 0; stallreq_ex_i = 0; stallreq_mem_i = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; clr();
        mem_valid_i = 1; exc_syscall_i = 1; stallreq_mem_i = 1; mem_pc_i = 32'h40;
        #1;
        n_cmp++; if (flush_o !== 1'b0) begin n_bad++; $display("FAIL rst_flush got %b want 0", flush_o); end
        n_cmp++; if (excepttype_o !== 32'h0) begin n_bad++; $display("FAIL rst_type got %h want 0", excepttype_o); end
        n_cmp++; if (stall_o !== 6'b0) begin n_bad++; $display("FAIL rst_stall got %b want 000000", stall_o); end
        n_cmp++; if (exc_pc_o !== 32'h0) begin n_bad++; $display("FAIL rst_pc got %h want 0", exc_pc_o); end
        tick(); tick();
        rst = 0; clr();
        #1;
        n_cmp++; if (exc_cnt_o !== 4'd0) begin n_bad++; $display("FAIL rst_cnt got %0d want 0", exc_cnt_o); end
        n_cmp++; if (flush_o !== 1'b0) begin n_bad++; $display("FAIL idle_flush got %b want 0", flush_o); end
        tick();
    endtask

    task automatic test_syscall();
        clr(); mem_valid_i = 1; exc_syscall_i = 1; mem_pc_i = 32'h100; mem_in_delayslot_i = 1;
        #1;
        n_cmp++; if (excepttype_o !== 32'h8) begin n_bad++; $display("FAIL sys_type got %h want 8", excepttype_o); end
        n_cmp++; if (flush_o !== 1'b1) begin n_bad++; $display("FAIL sys_flush got %b want 1", flush_o); end
        n_cmp++; if (new_pc_o !== 32'h20) begin n_bad++; $display("FAIL sys_newpc got %h want 20", new_pc_o); end
        n_cmp++; if (exc_pc_o !== 32'h100) begin n_bad++; $display("FAIL sys_epc got %h want 100", exc_pc_o); end
        n_cmp++; if (exc_in_delayslot_o !== 1'b1) begin n_bad++; $display("FAIL sys_ds got %b want 1", exc_in_delayslot_o); end
        tick(); clr();
        #1;
        n_cmp++; if (flush_o !== 1'b0) begin n_bad++; $display("FAIL sys_blackout got %b want 0", flush_o); end
        n_cmp++; if (exc_cnt_o !== 4'd1) begin n_bad++; $display("FAIL sys_cnt got %0d want 1", exc_cnt_o); end
        tick();
    endtask

    task automatic test_eret();
        clr(); mem_valid_i = 1; exc_eret_i = 1; cp0_epc_i = 32'h200;
        wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h300;
        #1;
        n_cmp++; if (excepttype_o !== 32'he) begin n_bad++; $display("FAIL eret_type got %h want e", excepttype_o); end
        n_cmp++; if (new_pc_o !== 32'h300) begin n_bad++; $display("FAIL eret_newpc got %h want 300", new_pc_o); end
        tick(); clr(); tick();
        n_cmp++; if (exc_cnt_o !== 4'd2) begin n_bad++; $display("FAIL eret_cnt got %0d want 2", exc_cnt_o); end
    endtask

    task automatic test_interrupt();
        clr(); cp0_cause_i = 32'h400; cp0_status_i = 32'h401; mem_valid_i = 1;
        wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd12; wb_cp0_data_i = 32'h400;
        #1;
        n_cmp++; if (flush_o !== 1'b0) begin n_bad++; $display("FAIL int_ie_fwd got %b want 0", flush_o); end
        tick();
        wb_cp0_we_i = 0; mem_valid_i = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (flush_o !== 1'b0) begin n_bad++; $display("FAIL int_bubble%0d got %b want 0", i, flush_o); end
            tick();
        end
        mem_valid_i = 1;
        #1;
        n_cmp++; if (excepttype_o !== 32'h1) begin n_bad++; $display("FAIL int_type got %h want 1", excepttype_o); end
        n_cmp++; if (new_pc_o !== 32'h20) begin n_bad++; $display("FAIL int_newpc got %h want 20", new_pc_o); end
        tick();
        #1;
        n_cmp++; if (flush_o !== 1'b0) begin n_bad++; $display("FAIL int_blackout got %b want 0", flush_o); end
        tick(); clr();
        mem_valid_i = 1; cp0_status_i = 32'h101;
        wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd13; wb_cp0_data_i = 32'h100;
        #1;
        n_cmp++; if (excepttype_o !== 32'h1) begin n_bad++; $display("FAIL int_cause_fwd got %h want 1", excepttype_o); end
        tick(); clr(); tick();
        n_cmp++; if (exc_cnt_o !== 4'd4) begin n_bad++; $display("FAIL int_cnt got %0d want 4", exc_cnt_o); end
    endtask

    task automatic test_priority();
        clr(); mem_valid_i = 1; exc_ri_i = 1; exc_ov_i = 1;
        #1;
        n_cmp++; if (excepttype_o !== 32'ha) begin n_bad++; $display("FAIL prio_ri_ov got %h want a", excepttype_o); end
        tick(); clr(); tick();
        mem_valid_i = 1; exc_fetch_adel_i = 1; exc_ri_i = 1; mem_pc_i = 32'h44; mem_addr_i = 32'h99;
        #1;
        n_cmp++; if (excepttype_o !== 32'h4) begin n_bad++; $display("FAIL prio_fadel got %h want 4", excepttype_o); end
        n_cmp++; if (badvaddr_o !== 32'h44) begin n_bad++; $display("FAIL prio_bva got %h want 44", badvaddr_o); end
        tick(); clr(); tick();
        mem_valid_i = 0; exc_trap_i = 1;
        #1;
        n_cmp++; if (flush_o !== 1'b0) begin n_bad++; $display("FAIL prio_bubble got %b want 0", flush_o); end
        mem_valid_i = 1; exc_break_i = 1; exc_ades_i = 1;
        #1;
        n_cmp++; if (excepttype_o !== 32'h9) begin n_bad++; $display("FAIL prio_bp_tr got %h want 9", excepttype_o); end
        tick(); clr(); tick();
        n_cmp++; if (exc_cnt_o !== 4'd7) begin n_bad++; $display("FAIL prio_cnt got %0d want 7", exc_cnt_o); end
    endtask

    task automatic test_back_to_back();
        clr(); mem_valid_i = 1; exc_syscall_i = 1;
        #1;
        n_cmp++; if (flush_o !== 1'b1) begin n_bad++; $display("FAIL b2b_first got %b want 1", flush_o); end
        tick();
        #1;
        n_cmp++; if (excepttype_o !== 32'h0) begin n_bad++; $display("FAIL b2b_second got %h want 0", excepttype_o); end
        tick(); clr();
        n_cmp++; if (exc_cnt_o !== 4'd8) begin n_bad++; $display("FAIL b2b_cnt got %0d want 8", exc_cnt_o); end
        tick();
    endtask

    task automatic test_stall();
        clr(); stallreq_ex_i = 1;
        #1;
        n_cmp++; if (stall_o !== 6'b001111) begin n_bad++; $display("FAIL stall_ex got %b want 001111", stall_o); end
        stallreq_mem_i = 1; stallreq_id_i = 1;
        #1;
        n_cmp++; if (stall_o !== 6'b011111) begin n_bad++; $display("FAIL stall_mem got %b want 011111", stall_o); end
        stallreq_mem_i = 0; stallreq_ex_i = 0;
        #1;
        n_cmp++; if (stall_o !== 6'b000111) begin n_bad++; $display("FAIL stall_id got %b want 000111", stall_o); end
        stallreq_id_i = 0; stallreq_ex_i = 1; mem_valid_i = 1; exc_adel_i = 1; mem_addr_i = 32'h1001;
        #1;
        n_cmp++; if (stall_o !== 6'b0) begin n_bad++; $display("FAIL stall_flush got %b want 000000", stall_o); end
        n_cmp++; if (excepttype_o !== 32'h4) begin n_bad++; $display("FAIL stall_adel got %h want 4", excepttype_o); end
        n_cmp++; if (badvaddr_o !== 32'h1001) begin n_bad++; $display("FAIL stall_bva got %h want 1001", badvaddr_o); end
        tick(); clr(); tick();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 7; i++) begin
            clr(); mem_valid_i = 1; exc_syscall_i = 1;
            tick(); clr(); tick();
        end
        n_cmp++; if (exc_cnt_o !== 4'hf) begin n_bad++; $display("FAIL sat_reach got %0d want 15", exc_cnt_o); end
        for (int i = 0; i < 3; i++) begin
            clr(); mem_valid_i = 1; exc_syscall_i = 1;
            tick(); clr(); tick();
        end
        n_cmp++; if (exc_cnt_o !== 4'hf) begin n_bad++; $display("FAIL sat_hold got %0d want 15", exc_cnt_o); end
    endtask

    task automatic test_rst_blackout();
        clr(); mem_valid_i = 1; exc_syscall_i = 1;
        tick();
        rst = 1;
        #1;
        n_cmp++; if (flush_o !== 1'b0) begin n_bad++; $display("FAIL rstbo_flush got %b want 0", flush_o); end
        tick();
        rst = 0;
        #1;
        n_cmp++; if (exc_cnt_o !== 4'd0) begin n_bad++; $display("FAIL rstbo_cnt got %0d want 0", exc_cnt_o); end
        n_cmp++; if (flush_o !== 1'b1) begin n_bad++; $display("FAIL rstbo_idle got %b want 1", flush_o); end
        tick(); clr(); tick();
    endtask

    initial begin
        test_reset();
        test_syscall();
        test_eret();
        test_interrupt();
        test_priority();
        test_back_to_back();
        test_stall();
        test_saturate();
        test_rst_blackout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
